// File: rtl/seq_signed_or_unsigned_mul.sv
// Iterative n-cycle shift-add multiplier with per-operand signedness.
// Optional macro SEQ_MUL_EARLY_TERM_EN: zero operand finishes in one cycle.
module seq_signed_or_unsigned_mul #(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           arg_vld,
    output logic           arg_rdy,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    input  logic           a_signed,
    input  logic           b_signed,
    output logic           res_vld,
    input  logic           res_rdy,
    output logic [2*n-1:0] res,
    output logic           busy
);

    localparam int CW = (n > 2) ? $clog2(n) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             init_q, init_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [n:0]       a_ext_q, a_ext_d;
    logic             bsgn_q, bsgn_d;
    logic [n:0]       hi_q, hi_d;
    logic [n-1:0]     lo_q, lo_d;
    logic [2*n-1:0]   res_q, res_d;

    logic             accept;
    logic             last;
    logic             sub;
    logic [n:0]       addend;
    logic [n:0]       sum;
    logic             carry;
    logic             msb;

    assign arg_rdy = (state_q == IDLE) && init_q;
    assign res_vld = (state_q == DONE);
    assign busy    = (state_q != IDLE);
    assign res     = res_q;
    assign accept  = arg_vld & arg_rdy;

    // Signed partial-product step: the top multiplier bit of a signed
    // operand carries negative weight, so the last step subtracts.
    always_comb begin
        last   = (cnt_q == CW'(n - 1));
        sub    = last & bsgn_q & lo_q[0];
        addend = '0;
        if (lo_q[0]) begin
            addend = sub ? ~a_ext_q : a_ext_q;
        end
        {carry, sum} = {1'b0, hi_q} + {1'b0, addend} + {{(n+1){1'b0}}, sub};
        // Sign of the exact (n+2)-bit sum from the n+1-bit adder's carry.
        msb = hi_q[n] ^ addend[n] ^ carry;
    end

    always_comb begin
        state_d = state_q;
        init_d  = 1'b1;
        cnt_d   = cnt_q;
        a_ext_d = a_ext_q;
        bsgn_d  = bsgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_ext_d = {a_signed & a[n-1], a};
                    bsgn_d  = b_signed;
                    hi_d    = '0;
                    lo_d    = b;
                    cnt_d   = '0;
                    state_d = BUSY;
`ifdef SEQ_MUL_EARLY_TERM_EN
                    if ((a == '0) || (b == '0)) begin
                        res_d   = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                hi_d  = {msb, sum[n:1]};
                lo_d  = {sum[0], lo_q[n-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    cnt_d   = '0;
                    res_d   = {sum, lo_q[n-1:1]};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
            cnt_q   <= '0;
            a_ext_q <= '0;
            bsgn_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            cnt_q   <= cnt_d;
            a_ext_q <= a_ext_d;
            bsgn_q  <= bsgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
        end
    end

endmodule
